hack_word_uart_tx: RTL

- Reads a 16-bit word out of the CPU datapath and transmits it as two standard 8N1 UART frames, low byte first.
- Acts as the read-out end of the 16-bit register interface. Another block drives `in`/`load` exactly as it would write a register; this block latches the word and serializes it off-chip.
- Used for debug dump of A/D/PC values and as the output device of the FPGA build.

---
 rtl/hack_word_uart_tx.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/hack_word_uart_tx.sv
// hack_word_uart_tx
// -----------------
// Serialises one 16-bit word from the CPU datapath as two 8N1 UART frames,
// low byte first. It is the read-out end of the 16-bit register interface:
// a writer presents the word on `in` and strobes `load`, the block latches
// the word and shifts it off-chip.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit (>= 2)
//
// Ports:
//   clk      system clock, all state changes on its rising edge
//   reset_n  asynchronous active-low reset
//   in       word to transmit, sampled only on the accepting edge
//   load     transmit request, accepted on an edge where ready=1
//   ready    1 = idle, a word can be accepted
//   tx       UART serial line, idle high, registered
//   done     one-cycle pulse when the second stop bit has completed
module hack_word_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] in,
    input  logic        load,
    output logic        ready,
    output logic        tx,
    output logic        done
);

    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state, state_next;
    logic [15:0] shift_reg, shift_next;
    logic [DIV_W-1:0] div_cnt, div_next;
    logic [2:0]  bit_idx, bit_next;
    logic        byte_idx, byte_next;
    logic        tx_next, ready_next, done_next;
    logic        bit_end;

    // Last cycle of the current bit period; every state advances only here.
    assign bit_end = (div_cnt == DIV_LAST);

    // State and output register. The serial outputs are computed one cycle
    // ahead in the combinational block so that tx/ready/done come straight
    // from flops and cannot glitch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            div_cnt   <= '0;
            bit_idx   <= '0;
            byte_idx  <= 1'b0;
            tx        <= 1'b1;
            ready     <= 1'b1;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            div_cnt   <= div_next;
            bit_idx   <= bit_next;
            byte_idx  <= byte_next;
            tx        <= tx_next;
            ready     <= ready_next;
            done      <= done_next;
        end
    end

    // Next-state logic. The word is shifted right once per data bit, so
    // after the eight low-byte shifts the high byte already sits in
    // shift_reg[7:0] and the second frame needs no byte select.
    always_comb begin
        state_next = state;
        shift_next = shift_reg;
        div_next   = div_cnt;
        bit_next   = bit_idx;
        byte_next  = byte_idx;
        tx_next    = tx;
        ready_next = ready;
        done_next  = 1'b0;

        if (state != IDLE) begin
            div_next = bit_end ? '0 : div_cnt + DIV_W'(1);
        end

        unique case (state)
            IDLE: begin
                tx_next    = 1'b1;
                ready_next = 1'b1;
                if (load) begin
                    shift_next = in;
                    byte_next  = 1'b0;
                    bit_next   = 3'd0;
                    div_next   = '0;
                    state_next = START;
                    tx_next    = 1'b0;
                    ready_next = 1'b0;
                end
            end

            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    bit_next   = 3'd0;
                    tx_next    = shift_reg[0];
                end
            end

            DATA: begin
                if (bit_end) begin
                    shift_next = {1'b0, shift_reg[15:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                        tx_next  = shift_reg[1];
                    end
                end
            end

            STOP: begin
                if (bit_end) begin
                    if (!byte_idx) begin
                        // High byte follows immediately, no idle gap.
                        byte_next  = 1'b1;
                        state_next = START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                        ready_next = 1'b1;
                        done_next  = 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                ready_next = 1'b1;
            end
        endcase
    end

endmodule
